piso_stream: RTL and testbench

- Parametrised parallel-in/serial-out shifter.
- Each parallel word is accepted through a valid/ready handshake and emitted one bit per cycle on a serial stream.
- The serial stream has its own valid/ready backpressure, a selectable bit order and an end-of-word marker.
- Sits between a word-wide producer and a bit-serial link or encoder; it is the successor to the fixed 4-bit MSB-first shifter.

---
 rtl/piso_stream_pkg.sv | 21 ++
 rtl/piso_stream_if.sv | 26 ++
 rtl/piso_stream.sv | 74 +++++++
 tb/tb_piso_stream.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/piso_stream_pkg.sv
// rtl/piso_stream_pkg.sv - shared types and helpers for the piso_stream shifter
package piso_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Widest word the parity helper folds; narrower words are zero-extended, which keeps the parity.
  localparam int PAR_W = 64;

  // Wide enough to hold WIDTH+1 so the parity build shares the same counter width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

  function automatic logic even_parity(input logic [PAR_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// rtl/piso_stream_if.sv - parallel load and serial output handshake bundle for piso_stream
interface piso_stream_if #(
  parameter int WIDTH = 8
);
  import piso_stream_pkg::*;

  logic [WIDTH-1:0] pi;
  logic             pi_valid;
  logic             pi_ready;
  logic             so;
  logic             so_valid;
  logic             so_ready;
  logic             so_last;
  logic             busy;

  modport master (
    output pi, pi_valid, so_ready,
    input  pi_ready, so, so_valid, so_last, busy
  );

  modport slave (
    input  pi, pi_valid, so_ready,
    output pi_ready, so, so_valid, so_last, busy
  );

endinterface

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in/serial-out shifter; PISO_STREAM_PARITY_EN appends an even-parity bit
module piso_stream
  import piso_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input logic         clk,
  input logic         rst,
  piso_stream_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
`ifdef PISO_STREAM_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  state_t           r_state;
  logic [NBITS-1:0] r_sh;
  logic [CW-1:0]    r_cnt;

  logic             w_so_valid;
  logic             w_so_last;
  logic             w_pi_ready;
  logic             w_load;
  logic             w_take;
  logic [NBITS-1:0] w_word;

`ifdef PISO_STREAM_PARITY_EN
  logic w_par;
  assign w_par  = even_parity(PAR_W'(bus.pi));
  // Parity sits just past the last data bit in the shift direction.
  assign w_word = (MSB_FIRST != 0) ? {bus.pi, w_par} : {w_par, bus.pi};
`else
  assign w_word = bus.pi;
`endif

  assign w_so_valid = (r_state == SHIFT);
  assign w_so_last  = w_so_valid && (r_cnt == CW'(1));
  assign w_pi_ready = !w_so_valid || (w_so_last && bus.so_ready);
  assign w_load     = bus.pi_valid && w_pi_ready;
  assign w_take     = w_so_valid && bus.so_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_state <= SHIFT;
      r_sh    <= w_word;
      r_cnt   <= CW'(NBITS);
    end else if (w_take) begin
      if (r_cnt == CW'(1)) begin
        r_state <= IDLE;
        r_sh    <= '0;
        r_cnt   <= '0;
      end else begin
        r_sh  <= (MSB_FIRST != 0) ? (r_sh << 1) : (r_sh >> 1);
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // The current bit always sits at the outgoing end, so so is 0 whenever the register is cleared.
  assign bus.so       = (MSB_FIRST != 0) ? r_sh[NBITS-1] : r_sh[0];
  assign bus.so_valid = w_so_valid;
  assign bus.so_last  = w_so_last;
  assign bus.pi_ready = w_pi_ready;
  assign bus.busy     = w_so_valid;

endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - directed self-checking bench for piso_stream (MSB-first and LSB-first instances)
module tb_piso_stream;
  import piso_stream_pkg::*;

  localparam int W = 8;
`ifdef PISO_STREAM_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  int   vcount;

  piso_stream_if #(.WIDTH(W)) b1 ();
  piso_stream_if #(.WIDTH(W)) b0 ();

  piso_stream #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (.clk(clk), .rst(rst), .bus(b1));
  piso_stream #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (.clk(clk), .rst(rst), .bus(b0));

  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit lsb);
    if (i >= W) return ^w;
    return lsb ? w[i] : w[W-1-i];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Load one word on the chosen instance with so_ready held high and check every emitted bit.
  task automatic run_word(input bit lsb, input logic [W-1:0] w);
    string nm;
    nm = $sformatf("%s_%h", lsb ? "lsb" : "msb", w);
    if (lsb) begin
      b0.pi = w; b0.pi_valid = 1'b1; b0.so_ready = 1'b1;
      check({nm, "_load_ready"}, b0.pi_ready, 1'b1);
    end else begin
      b1.pi = w; b1.pi_valid = 1'b1; b1.so_ready = 1'b1;
      check({nm, "_load_ready"}, b1.pi_ready, 1'b1);
    end
    tick();
    b0.pi_valid = 1'b0;
    b1.pi_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s_valid%0d", nm, i), lsb ? b0.so_valid : b1.so_valid, 1'b1);
      check($sformatf("%s_bit%0d", nm, i), lsb ? b0.so : b1.so, exp_bit(w, i, lsb));
      check($sformatf("%s_last%0d", nm, i), lsb ? b0.so_last : b1.so_last, (i == NB - 1));
      tick();
    end
    check({nm, "_end_valid"}, lsb ? b0.so_valid : b1.so_valid, 1'b0);
    check({nm, "_end_so"}, lsb ? b0.so : b1.so, 1'b0);
    check({nm, "_end_last"}, lsb ? b0.so_last : b1.so_last, 1'b0);
    check({nm, "_end_busy"}, lsb ? b0.busy : b1.busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    b1.pi = 8'hFF; b1.pi_valid = 1'b1; b1.so_ready = 1'b1;
    b0.pi = 8'h00; b0.pi_valid = 1'b0; b0.so_ready = 1'b1;
    tick();
    tick();
    check("rst_so", b1.so, 1'b0);
    check("rst_so_valid", b1.so_valid, 1'b0);
    check("rst_so_last", b1.so_last, 1'b0);
    check("rst_busy", b1.busy, 1'b0);
    check("rst_pi_ready", b1.pi_ready, 1'b1);
    check("rst_lsb_so_valid", b0.so_valid, 1'b0);
    rst = 1'b0;
    b1.pi_valid = 1'b0;
    tick();
    check("idle_so_valid", b1.so_valid, 1'b0);

    run_word(1'b0, 8'hA5);
    run_word(1'b1, 8'hA5);
    run_word(1'b1, 8'h01);

    // Back-to-back words with pi_valid held high: no bubble between them.
    b1.pi = 8'hF0; b1.pi_valid = 1'b1; b1.so_ready = 1'b1;
    tick();
    b1.pi = 8'h0F;
    for (int i = 0; i < 2 * NB; i++) begin
      check($sformatf("b2b_valid%0d", i), b1.so_valid, 1'b1);
      check($sformatf("b2b_bit%0d", i), b1.so,
            exp_bit((i < NB) ? 8'hF0 : 8'h0F, i % NB, 1'b0));
      check($sformatf("b2b_last%0d", i), b1.so_last, ((i % NB) == NB - 1));
      check($sformatf("b2b_ready%0d", i), b1.pi_ready, ((i % NB) == NB - 1));
      tick();
      if (i == NB - 1) b1.pi_valid = 1'b0;
    end
    check("b2b_end_valid", b1.so_valid, 1'b0);

    // Backpressure: stall three cycles while bit 2 is presented.
    b1.pi = 8'hC3; b1.pi_valid = 1'b1; b1.so_ready = 1'b1;
    tick();
    b1.pi_valid = 1'b0;
    vcount = 0;
    for (int i = 0; i < NB; i++) begin
      if (i == 2) begin
        for (int s = 0; s < 3; s++) begin
          b1.so_ready = 1'b0;
          check($sformatf("bp_stall_bit%0d", s), b1.so, exp_bit(8'hC3, 2, 1'b0));
          check($sformatf("bp_stall_last%0d", s), b1.so_last, 1'b0);
          check($sformatf("bp_stall_ready%0d", s), b1.pi_ready, 1'b0);
          if (b1.so_valid) vcount++;
          tick();
        end
        b1.so_ready = 1'b1;
      end
      check($sformatf("bp_bit%0d", i), b1.so, exp_bit(8'hC3, i, 1'b0));
      check($sformatf("bp_last%0d", i), b1.so_last, (i == NB - 1));
      if (b1.so_valid) vcount++;
      tick();
    end
    check("bp_end_valid", b1.so_valid, 1'b0);
    check_int("bp_valid_cycles", vcount, NB + 3);

    // Reset mid-word discards the word; a fresh load then emits cleanly.
    b1.pi = 8'hFF; b1.pi_valid = 1'b1; b1.so_ready = 1'b1;
    tick();
    b1.pi_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_pre_valid", b1.so_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", b1.so_valid, 1'b0);
    check("mid_rst_ready", b1.pi_ready, 1'b1);
    check("mid_rst_so", b1.so, 1'b0);
    check("mid_rst_last", b1.so_last, 1'b0);
    run_word(1'b1, 8'h81);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
